// File: rtl/fetch_queue.sv
// Instruction fetch unit: one outstanding imem request at a time, responses
// buffered in a DEPTH-entry FIFO that presents its head combinationally to decode.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  input  logic        inst_ready_i
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_WAIT_DISCARD
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW:0]   count_q, count_d;
  logic [31:0]   inst_mem_q [DEPTH];
  logic [31:0]   pc_mem_q   [DEPTH];
  logic          grant, push, pop;

  always_comb begin
    // A request is only issued when a queue slot is free, so its response can always be pushed.
    imem_req_o = !rst_i && (state_q == S_IDLE) && !redirect_i && (count_q < FULL_CNT);
    grant      = imem_req_o && imem_gnt_i;
    push       = (state_q == S_WAIT) && imem_rvalid_i && !redirect_i;
    pop        = (count_q != '0) && inst_ready_i && !redirect_i;

    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    rptr_d     = rptr_q;
    wptr_d     = wptr_q;
    count_d    = count_q;

    unique case (state_q)
      S_IDLE: begin
        if (grant) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid_i)   state_d = S_IDLE;
        else if (redirect_i) state_d = S_WAIT_DISCARD;
      end
      S_WAIT_DISCARD: begin
        if (imem_rvalid_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (redirect_i) begin
      fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
      rptr_d     = '0;
      wptr_d     = '0;
      count_d    = '0;
    end else begin
      if (grant) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        req_pc_d   = fetch_pc_q;
      end
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      rptr_q     <= '0;
      wptr_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      rptr_q     <= rptr_d;
      wptr_q     <= wptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && push) begin
      inst_mem_q[wptr_q] <= imem_rdata_i;
      pc_mem_q[wptr_q]   <= req_pc_q;
    end
  end

  assign imem_addr_o  = fetch_pc_q;
  assign inst_valid_o = (count_q != '0);
  assign inst_o       = inst_valid_o ? inst_mem_q[rptr_q] : NOP_INST;
  assign pc_o         = inst_valid_o ? pc_mem_q[rptr_q] : 32'h0000_0000;

endmodule
